// File: rtl/fifo_sum_reducer.sv
// Pops elements from a first-word fall-through fifo and emits the sum of each group of GROUP
// elements. A flush closes a partial group early.
module fifo_sum_reducer #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned GROUP = 4,
  parameter int unsigned SUMW  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [DATAW-1:0] fifo_rdata,
  output logic             fifo_r,
  input  logic             flush,
  output logic [SUMW-1:0]  sum_data,
  output logic             sum_partial,
  output logic             sum_valid,
  input  logic             sum_ready
);

  localparam int unsigned CNTW = $clog2(GROUP + 1);
  localparam logic [CNTW-1:0] GroupCnt = CNTW'(GROUP);

  typedef enum logic {StAcc, StHold} state_e;

  state_e            state_q, state_d;
  logic [SUMW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [SUMW-1:0]   sum_data_q, sum_data_d;
  logic              partial_q, partial_d;

  logic              pop;
  logic [CNTW-1:0]   cnt_inc;
  logic [SUMW-1:0]   acc_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StAcc;
      acc_q      <= '0;
      cnt_q      <= '0;
      sum_data_q <= '0;
      partial_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sum_data_q <= sum_data_d;
      partial_q  <= partial_d;
    end
  end

  always_comb begin
    // Gating with rst keeps the pop request low for the whole reset, not just after its edge.
    pop     = (state_q == StAcc) && !fifo_empty && !rst;
    cnt_inc = cnt_q + {{(CNTW-1){1'b0}}, pop};
    acc_inc = acc_q + (pop ? SUMW'(fifo_rdata) : '0);

    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum_data_d = sum_data_q;
    partial_d  = partial_q;

    unique case (state_q)
      StAcc: begin
        acc_d = acc_inc;
        cnt_d = cnt_inc;
        // A same-cycle pop counts toward the group being closed by flush.
        if ((pop && (cnt_inc == GroupCnt)) || (flush && (cnt_inc != '0))) begin
          state_d    = StHold;
          sum_data_d = acc_inc;
          partial_d  = (cnt_inc != GroupCnt);
        end
      end
      StHold: begin
        if (sum_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  assign fifo_r      = pop;
  assign sum_valid   = (state_q == StHold) && !rst;
  assign sum_data    = sum_data_q;
  assign sum_partial = partial_q;

endmodule

// File: tb/tb_fifo_sum_reducer.sv
// Directed bench for fifo_sum_reducer: a queue models the upstream fall-through fifo.
module tb_fifo_sum_reducer;

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_r;
  logic       flush;
  logic [9:0] sum_data;
  logic       sum_partial;
  logic       sum_valid;
  logic       sum_ready;

  int errors;
  int checks;

  logic [7:0] q[$];
  bit         bubble;

  fifo_sum_reducer #(
    .DATAW(8),
    .GROUP(4),
    .SUMW (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_r     (fifo_r),
    .flush      (flush),
    .sum_data   (sum_data),
    .sum_partial(sum_partial),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive();
    fifo_empty = bubble || (q.size() == 0);
    fifo_rdata = fifo_empty ? 8'd0 : q[0];
  endtask

  // One clock: the model fifo pops when the DUT requested a pop of a non-empty head.
  task automatic tick();
    bit         pop;
    logic [7:0] tmp;
    drive();
    #1;
    pop = fifo_r && !fifo_empty;
    @(posedge clk);
    if (pop) tmp = q.pop_front();
    #1;
    drive();
    #1;
  endtask

  task automatic do_reset();
    q.delete();
    bubble    = 1'b0;
    flush     = 1'b0;
    sum_ready = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive();
    #1;
  endtask

  task automatic test_reset();
    int n;
    q.delete();
    bubble    = 1'b0;
    flush     = 1'b0;
    sum_ready = 1'b0;
    rst       = 1'b1;
    q.push_back(8'd7);
    tick();
    tick();
    checks++;
    if (fifo_r !== 1'b0) begin
      errors++; $display("FAIL reset_fifo_r got=%b want=0", fifo_r);
    end
    checks++;
    if (sum_valid !== 1'b0 || sum_partial !== 1'b0 || sum_data !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b partial=%b data=%0d want 0/0/0",
               sum_valid, sum_partial, sum_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_r !== 1'b1) begin
      errors++; $display("FAIL reset_first_pop got=%b want=1", fifo_r);
    end
    // Reach HOLD, then reset with sum_ready=1: result must be discarded.
    q.push_back(8'd1); q.push_back(8'd1); q.push_back(8'd1);
    n = 0;
    while (!sum_valid && n < 40) begin tick(); n++; end
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 10'd10) begin
      errors++; $display("FAIL reset_prefill got valid=%b data=%0d want 1/10", sum_valid, sum_data);
    end
    sum_ready = 1'b1;
    rst       = 1'b1;
    tick();
    checks++;
    if (sum_valid !== 1'b0 || sum_data !== 10'd0) begin
      errors++; $display("FAIL reset_hold_discard got valid=%b data=%0d want 0/0", sum_valid, sum_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int cyc[$];
    logic [9:0] got[$];
    do_reset();
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (sum_valid) begin
        cyc.push_back(c);
        got.push_back(sum_data);
        checks++;
        if (fifo_r !== 1'b0 || sum_partial !== 1'b0) begin
          errors++;
          $display("FAIL stream_hold_cycle%0d got fifo_r=%b partial=%b want 0/0", c, fifo_r, sum_partial);
        end
      end
    end
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL stream_count got=%0d want=2", got.size());
    end else begin
      checks++;
      if (got[0] !== 10'd10 || got[1] !== 10'd26) begin
        errors++; $display("FAIL stream_sums got=%0d,%0d want=10,26", got[0], got[1]);
      end
      checks++;
      if (cyc[0] != 4 || cyc[1] != 9) begin
        errors++; $display("FAIL stream_latency got cycles %0d,%0d want 4,9", cyc[0], cyc[1]);
      end
    end
  endtask

  task automatic test_hold();
    int n;
    do_reset();
    sum_ready = 1'b0;
    for (int i = 1; i <= 4; i++) q.push_back(8'(i));
    q.push_back(8'd20);
    n = 0;
    while (!sum_valid && n < 40) begin tick(); n++; end
    checks++;
    if (!sum_valid) begin
      errors++; $display("FAIL hold_timeout got valid=0 want 1");
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sum_valid !== 1'b1 || sum_data !== 10'd10 || fifo_r !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable%0d got valid=%b data=%0d fifo_r=%b want 1/10/0",
                 i, sum_valid, sum_data, fifo_r);
      end
    end
    sum_ready = 1'b1;
    tick();
    checks++;
    if (sum_valid !== 1'b0 || q.size() != 1) begin
      errors++;
      $display("FAIL hold_transfer got valid=%b queue=%0d want 0/1", sum_valid, q.size());
    end
  endtask

  task automatic test_flush_partial();
    int n;
    do_reset();
    sum_ready = 1'b0;
    bubble    = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty_ignored got valid=%b want 0", sum_valid);
    end
    bubble = 1'b0;
    q.push_back(8'd9); q.push_back(8'd10); q.push_back(8'd11);
    tick(); tick(); tick();
    bubble = 1'b1;
    tick();
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++; $display("FAIL flush_bubble_stall got valid=%b want 0", sum_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 10'd30 || sum_partial !== 1'b1) begin
      errors++;
      $display("FAIL flush_partial got valid=%b data=%0d partial=%b want 1/30/1",
               sum_valid, sum_data, sum_partial);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 10'd30 || sum_partial !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_hold got valid=%b data=%0d partial=%b want 1/30/1",
               sum_valid, sum_data, sum_partial);
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    bubble    = 1'b0;
    for (int i = 1; i <= 4; i++) q.push_back(8'(i));
    n = 0;
    while (!sum_valid && n < 40) begin tick(); n++; end
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 10'd10 || sum_partial !== 1'b0) begin
      errors++;
      $display("FAIL flush_next_group got valid=%b data=%0d partial=%b want 1/10/0",
               sum_valid, sum_data, sum_partial);
    end
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    sum_ready = 1'b0;
    q.push_back(8'd1); q.push_back(8'd2); q.push_back(8'd3);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 10'd6 || sum_partial !== 1'b1) begin
      errors++;
      $display("FAIL flush_same_pop got valid=%b data=%0d partial=%b want 1/6/1",
               sum_valid, sum_data, sum_partial);
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    for (int i = 1; i <= 4; i++) q.push_back(8'(i));
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 10'd10 || sum_partial !== 1'b0) begin
      errors++;
      $display("FAIL flush_full_group got valid=%b data=%0d partial=%b want 1/10/0",
               sum_valid, sum_data, sum_partial);
    end
  endtask

  task automatic test_max();
    int n;
    do_reset();
    sum_ready = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(8'd255);
    n = 0;
    while (!sum_valid && n < 40) begin tick(); n++; end
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 10'd1020 || sum_partial !== 1'b0) begin
      errors++;
      $display("FAIL max_sum got valid=%b data=%0d partial=%b want 1/1020/0",
               sum_valid, sum_data, sum_partial);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    sum_ready = 1'b0;
    q.push_back(8'd1); q.push_back(8'd2);
    q.push_back(8'd5); q.push_back(8'd6); q.push_back(8'd7); q.push_back(8'd8);
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (sum_valid !== 1'b0 || q.size() != 4) begin
      errors++;
      $display("FAIL reset_mid_discard got valid=%b queue=%0d want 0/4", sum_valid, q.size());
    end
    rst = 1'b0;
    n = 0;
    while (!sum_valid && n < 40) begin tick(); n++; end
    checks++;
    if (sum_valid !== 1'b1 || sum_data !== 10'd26 || n != 4) begin
      errors++;
      $display("FAIL reset_mid_next got valid=%b data=%0d cycles=%0d want 1/26/4",
               sum_valid, sum_data, n);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    sum_ready  = 1'b0;
    bubble     = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = 8'd0;
    test_reset();
    test_stream();
    test_hold();
    test_flush_partial();
    test_flush_same_cycle();
    test_max();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sum_reducer.md
FIFO_SUM_REDUCER -- requirements
Module: fifo_sum_reducer

Interface
REQ-001 Parameter DATAW, default 8, element width; matches the upstream fifo data width.
REQ-002 Parameter GROUP, default 4, elements summed per output word; legal range 2..16.
REQ-003 Parameter SUMW, default 10, sum width; SHALL be at least DATAW + ceil(log2(GROUP)).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 fifo_empty  in  1  upstream fifo empty flag.
REQ-007 fifo_rdata  in  DATAW  upstream fifo head data; valid whenever fifo_empty=0 (first-word fall-through).
REQ-008 fifo_r  out  1  pop request to upstream fifo; head is consumed at the edge where fifo_r=1 and fifo_empty=0.
REQ-009 flush  in  1  close the current partial group early.
REQ-010 sum_data  out  SUMW  unsigned sum of the closed group.
REQ-011 sum_partial  out  1  closed group held fewer than GROUP elements (closed by flush).
REQ-012 sum_valid  out  1  sum_data/sum_partial valid.
REQ-013 sum_ready  in  1  downstream accepts; transfer on edge with sum_valid=1 and sum_ready=1.

Function
REQ-014 Two states SHALL exist: ACC (collecting) and HOLD (presenting result).
REQ-015 fifo_r SHALL be combinational: 1 iff state=ACC and fifo_empty=0; fifo_r SHALL never be 1 while fifo_empty=1.
REQ-016 In ACC, each pop SHALL add zero-extended fifo_rdata to the accumulator and increment the element count.
REQ-017 A pop that brings the count to GROUP SHALL close the group: next cycle state=HOLD, sum_valid=1, sum_partial=0.
REQ-018 In ACC with flush=1 and count>0 (counting a same-cycle pop), the group SHALL close; the same-cycle popped element SHALL be included; sum_partial=1 if final count<GROUP, else 0.
REQ-019 flush with count=0 and no pop SHALL be ignored; flush in HOLD SHALL be ignored.
REQ-020 In HOLD: fifo_r=0; sum_data, sum_partial and sum_valid SHALL remain stable until transfer.
REQ-021 On transfer, the accumulator and count SHALL clear, and the next cycle SHALL be ACC with sum_valid=0.
REQ-022 Latency: sum_valid rises exactly one cycle after the closing edge; min period per full group = GROUP+1 cycles.
REQ-023 Bubbles (fifo_empty=1) in ACC SHALL stall accumulation without altering accumulator or count.
REQ-024 Arithmetic SHALL be unsigned modulo 2^SUMW; no overflow with legal parameters.

Reset
REQ-025 While rst=1: state=ACC, accumulator=0, count=0, sum_valid=0, sum_partial=0, sum_data=0, fifo_r=0.
REQ-026 rst SHALL take priority over pop, flush and transfer in the same cycle; a partial group or held result is discarded without output.
REQ-027 First pop may occur on the first edge after rst deasserts.

Verification
REQ-028 Stream 1..8 with fifo_empty=0 throughout, sum_ready=1 -> two results: 10 (partial=0) then 26 (partial=0); fifo_r=0 on each HOLD cycle.
REQ-029 Stream 1..4, sum_ready=0 for 5 cycles after sum_valid -> sum_data holds 10, sum_valid=1, fifo_r=0 throughout; transfer on first sum_ready=1 edge.
REQ-030 Push 9,10,11 then fifo_empty=1, flush pulse -> sum_data=30, sum_partial=1; subsequent group starts from 0.
REQ-031 Elements 1,2,3 available, flush asserted on the edge popping 3 -> sum_data=6, sum_partial=1; GROUP-th pop with flush -> partial=0.
REQ-032 Elements 255 x4 (DATAW=8) -> sum_data=1020, no wrap.
REQ-033 rst pulsed after 2 pops of a group -> no sum_valid; next 4 elements 5,6,7,8 -> sum_data=26.
